uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter on the CPU's data-store port. It decodes `dataAddr`/`we` from the core and queues written bytes in a small FIFO. It serialises them 8N1, LSB first, on `tx`, and returns a status word on `readData` for the top-level data-read mux. It is the first peripheral downstream of the single-cycle core and lets programs emit bytes without polling a shift register.

## Interface
- `BASE_ADDR`, 32'h0000_1000: register-block base; must be 8-byte aligned.
- `CLKS_PER_BIT`, 16: clocks per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, 4: TX FIFO entries; must be a power of 2 and ≥ 2.

Ports:
- `clk` input 1: single clock, rising edge.
- `n_reset` input 1: asynchronous, active-low reset.
- `dataAddr` input 32: core data address.
- `writeData` input 32: core store data; only [7:0] is used.
- `we` input 1: core store strobe, sampled on the rising `clk` edge.
- `readData` output 32: combinational register read data; 0 when the address does not hit the block.
- `tx` output 1: serial line, registered, idle high.
- `busy` output 1: serialiser active (state ≠ IDLE), registered.

## Operation
- **Address decode.** Hit when `dataAddr[31:3] == BASE_ADDR[31:3]`; `dataAddr[1:0]` is ignored.
  - `dataAddr[2]=0`: TXDATA.
  - `dataAddr[2]=1`: STATUS.
- **TXDATA write** (hit, `we=1`): push `writeData[7:0]`.
  - If the FIFO is full and no pop happens on the same edge, the byte is dropped and sticky `ovf` is set.
  - Push and pop on the same edge while full: the push is accepted and count is unchanged.
- **TXDATA read**: returns 0.
- **STATUS read**: `{28'b0, ovf, busy, empty, full}`.
- **STATUS write** (any data): clears `ovf`. If an overflow occurs on the same edge, `ovf` stays set.
- **Serialiser FSM**: IDLE → START → DATA → [PARITY] → STOP.
  - IDLE: `tx=1`. If the FIFO is not empty, pop into the shifter, clear the baud counter, and go to START.
  - START: `tx=0` for `CLKS_PER_BIT` cycles.
  - DATA: 8 bits, LSB first, each held `CLKS_PER_BIT` cycles. A 3-bit index counts 0..7.
  - STOP: `tx=1` for `CLKS_PER_BIT` cycles. At the end, if the FIFO is not empty, pop and go directly to START with no idle cycle; otherwise go to IDLE.
- **Baud counter**: `$clog2(CLKS_PER_BIT)` bits, counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on bit advance.
- **FIFO**: read/write pointers of `$clog2(FIFO_DEPTH)` bits that wrap modulo depth, plus a count of `$clog2(FIFO_DEPTH)+1` bits. `full` = count==`FIFO_DEPTH`; `empty` = count==0.

## Timing
- **Reset values**: `tx=1`, `busy=0`, state IDLE, FIFO empty, `ovf=0`. STATUS therefore reads 0x0000_0002.
- Reset is asynchronous. Asserting it mid-frame forces `tx=1` immediately and discards the FIFO contents.
- **Write-to-line latency**: a push on edge N (FIFO previously empty, IDLE) pops on edge N+1. `tx` falls after edge N+1 and `busy` rises after edge N+1.
- **Frame length**: 10·`CLKS_PER_BIT` cycles, or 11· with parity. `busy` stays high for exactly that many cycles per frame, and continuously across back-to-back frames.
- `readData` is purely combinational from `dataAddr` and the current state. It reflects the state before the pending edge, with zero latency, as the single-cycle core requires.
- Status flags update on the same edge as the push or pop that changes them.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles; the frame is 11 bit-times.
- `UART_TX_PARITY_EN` undefined: no PARITY state; the frame is 10 bit-times (8N1).

## Test plan
All scenarios use `CLKS_PER_BIT=4`, `FIFO_DEPTH=4`, `BASE_ADDR=0x1000`.
1. **Reset**: hold `n_reset=0`, then read 0x1004 → `tx=1`, `busy=0`, `readData=0x0000_0002`.
2. **Single byte**: write 0x55 to 0x1000 on edge N.
   - `tx` =0 during cycles N+1..N+4, then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 for 4 cycles.
   - `busy` is high for 40 cycles.
3. **Overflow**: six back-to-back writes 0x01..0x06 to 0x1000.
   - `full=1` after the 5th edge; 0x06 is dropped; STATUS reads 0x0000_000D (`ovf`, `busy`, `full`).
   - A write to 0x1004 clears `ovf`.
   - Bytes 0x01..0x05 are transmitted in order.
4. **Back-to-back**: write 0xA0 and then 0x0F on consecutive edges → the second start bit immediately follows the first stop bit; `busy` is high for 80 contiguous cycles.
5. **Address miss**: write 0x41 to 0x1008 and read 0x1008 → no `tx` activity, `readData=0`, STATUS unchanged.
6. **Reset mid-frame**: drop `n_reset` during data bit 3 → `tx=1` without a clock edge. After release STATUS reads 0x2 and nothing further is sent. With `UART_TX_PARITY_EN`, a 0x07 frame carries parity bit 1.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a small TX FIFO.
// TXDATA at BASE_ADDR+0 (write pushes a byte), STATUS at BASE_ADDR+4
// ({ovf, busy, empty, full}; any write clears ovf).
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (11 bit-times per frame).
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [31:0] dataAddr,
    input  logic [31:0] writeData,
    input  logic        we,
    output logic [31:0] readData,
    output logic        tx,
    output logic        busy
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t             state;
    logic [BAUD_W-1:0]  baudCnt;
    logic [2:0]         bitIdx;
    logic [7:0]         txByte;
`ifdef UART_TX_PARITY_EN
    logic               parityBit;
`endif

    logic [7:0]         fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wrPtr;
    logic [PTR_W-1:0]   rdPtr;
    logic [CNT_W-1:0]   fifoCount;
    logic               ovf;

    logic hit, pushReq, statusWr, baudDone;
    logic fifoEmpty, fifoFull, popNow, pushOk, overflow;
    logic unusedBits;

    // Only the low byte of store data is used and the byte lane is ignored.
    assign unusedBits = ^{writeData[31:8], dataAddr[1:0]};

    assign hit       = (dataAddr[31:3] == BASE_ADDR[31:3]);
    assign pushReq   = hit & we & ~dataAddr[2];
    assign statusWr  = hit & we & dataAddr[2];
    assign baudDone  = (baudCnt == BAUD_LAST);
    assign fifoEmpty = (fifoCount == '0);
    assign fifoFull  = (fifoCount == DEPTH_CNT);
    // The serialiser takes a byte when idle or when the stop bit finishes.
    assign popNow    = ~fifoEmpty & ((state == IDLE) | ((state == STOP) & baudDone));
    // A full FIFO still accepts a push if a pop frees a slot on the same edge.
    assign pushOk    = pushReq & (~fifoFull | popNow);
    assign overflow  = pushReq & ~pushOk;

    // Register read mux: zero-latency view of the current state.
    always_comb begin
        readData = 32'h0;
        if (hit && dataAddr[2]) begin
            readData = {28'h0, ovf, busy, fifoEmpty, fifoFull};
        end
    end

    // FIFO storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            fifoMem[wrPtr] <= writeData[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            ovf       <= 1'b0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + PTR_W'(1);
            if (popNow) rdPtr <= rdPtr + PTR_W'(1);
            case ({pushOk, popNow})
                2'b10:   fifoCount <= fifoCount + CNT_W'(1);
                2'b01:   fifoCount <= fifoCount - CNT_W'(1);
                default: fifoCount <= fifoCount;
            endcase
            // Overflow wins over a simultaneous clear.
            if (overflow)      ovf <= 1'b1;
            else if (statusWr) ovf <= 1'b0;
        end
    end

    // Shift register and parity: loaded on pop, shifted at each data-bit advance.
    always_ff @(posedge clk) begin
        if (popNow) begin
            txByte <= fifoMem[rdPtr];
`ifdef UART_TX_PARITY_EN
            parityBit <= ^fifoMem[rdPtr];
`endif
        end else if ((state == DATA) && baudDone) begin
            txByte <= txByte >> 1;
        end
    end

    // Serialiser FSM with registered tx/busy driven from the next state.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state   <= IDLE;
            baudCnt <= '0;
            bitIdx  <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (popNow) begin
                        state   <= START;
                        baudCnt <= '0;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (baudDone) begin
                        state   <= DATA;
                        baudCnt <= '0;
                        bitIdx  <= '0;
                        tx      <= txByte[0];
                    end else begin
                        baudCnt <= baudCnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baudDone) begin
                        baudCnt <= '0;
                        if (bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= parityBit;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bitIdx <= bitIdx + 3'd1;
                            tx     <= txByte[1];
                        end
                    end else begin
                        baudCnt <= baudCnt + BAUD_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baudDone) begin
                        state   <= STOP;
                        baudCnt <= '0;
                        tx      <= 1'b1;
                    end else begin
                        baudCnt <= baudCnt + BAUD_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (baudDone) begin
                        baudCnt <= '0;
                        if (popNow) begin
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else begin
                        baudCnt <= baudCnt + BAUD_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    baudCnt <= '0;
                    tx      <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Testbench for uart_tx_mmio: directed scenarios plus randomized register
// traffic, checked every cycle against a frame-level behavioural model.
`timescale 1ns/1ps
module tb_uart_tx_mmio;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_1000;
`ifdef UART_TX_PARITY_EN
    localparam int FBITS = 11;
`else
    localparam int FBITS = 10;
`endif
    localparam int FRAME = FBITS * CPB;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [31:0] dataAddr = BASE + 32'd4;
    logic [31:0] writeData = 32'h0;
    logic        we = 1'b0;
    logic [31:0] readData;
    logic        tx;
    logic        busy;

    uart_tx_mmio #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .dataAddr (dataAddr),
        .writeData(writeData),
        .we       (we),
        .readData (readData),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (frame level) ----------------
    logic [7:0] mq[$];
    logic [7:0] expSent[$];
    bit         mActive = 1'b0;
    int         mF = 0;
    logic [7:0] mCur = 8'h0;
    bit         mOvf = 1'b0;

    // Bit-time idx of a frame carrying byte d: start, 8 data LSB first, [parity], stop.
    function automatic logic frameBit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            mq.delete();
            mActive = 1'b0;
            mF = 0;
            mOvf = 1'b0;
        end else begin
            bit hitM, pushReq, statWr, pop, accept;
            hitM    = (dataAddr[31:3] == BASE[31:3]);
            pushReq = hitM && we && !dataAddr[2];
            statWr  = hitM && we && dataAddr[2];
            pop     = (mq.size() > 0) && (!mActive || mF == FRAME - 1);
            accept  = pushReq && ((mq.size() < DEPTH) || pop);
            if (statWr) mOvf = 1'b0;
            if (pushReq && !accept) mOvf = 1'b1;
            if (mActive) begin
                mF++;
                if (mF == FRAME) begin
                    expSent.push_back(mCur);
                    mActive = 1'b0;
                end
            end
            if (pop) begin
                mCur = mq.pop_front();
                mActive = 1'b1;
                mF = 0;
            end
            if (accept) mq.push_back(writeData[7:0]);
        end
    end

    function automatic logic expTx();
        return mActive ? frameBit(mCur, mF / CPB) : 1'b1;
    endfunction

    function automatic logic [31:0] expRead();
        if ((dataAddr[31:3] == BASE[31:3]) && dataAddr[2])
            return {28'h0, mOvf, mActive, (mq.size() == 0), (mq.size() == DEPTH)};
        return 32'h0;
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("tx", {31'h0, tx}, {31'h0, expTx()});
        check("busy", {31'h0, busy}, {31'h0, mActive});
        check("readData", readData, expRead());
    end

    // ---------------- line receiver ----------------
    logic [7:0] rxQ[$];
    bit         rxBusy = 1'b0;
    int         rxCnt = 0;
    logic [7:0] rxByte = 8'h0;
    logic       rxPar = 1'b0;

    always @(negedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rxBusy = 1'b0;
        end else if (!rxBusy) begin
            if (tx === 1'b0) begin
                rxBusy = 1'b1;
                rxCnt = 0;
            end
        end else begin
            rxCnt++;
            if (rxCnt % CPB == 1) begin
                int idx;
                idx = rxCnt / CPB;
                if (idx >= 1 && idx <= 8) rxByte[idx-1] = tx;
                else if (idx == FBITS - 1) begin
                    rxQ.push_back(rxByte);
                    rxBusy = 1'b0;
                end else rxPar = tx;
            end
        end
    end

    // busy run-length tracker
    int busyRun = 0;
    int lastRun = 0;
    always @(negedge clk) begin
        if (busy === 1'b1) busyRun++;
        else begin
            if (busyRun > 0) lastRun = busyRun;
            busyRun = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        dataAddr = addr;
        writeData = data;
        we = 1'b1;
        tick(1);
        we = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles);
        int k;
        k = 0;
        while ((busy !== 1'b0 || mq.size() != 0) && k < maxCycles) begin
            tick(1);
            k++;
        end
        checks++;
        if (k >= maxCycles) begin
            errors++;
            $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", k);
        end
    endtask

    task automatic clearLogs();
        rxQ.delete();
        expSent.delete();
        lastRun = 0;
    endtask

    task automatic checkRx(input string name, input logic [7:0] exp[$]);
        check({name, "_len"}, rxQ.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            if (i < rxQ.size()) check(name, {24'h0, rxQ[i]}, {24'h0, exp[i]});
    endtask

    logic [10:0] seq55;
    logic [7:0]  expBytes[$];

    initial begin
        // 1. reset
        tick(3);
        check("rst_tx", {31'h0, tx}, 32'd1);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_status", readData, 32'h0000_0002);
        n_reset = 1'b1;
        tick(2);

        // 2. single byte 0x55
        clearLogs();
`ifdef UART_TX_PARITY_EN
        seq55 = 11'h4AA;
`else
        seq55 = 11'h2AA;
`endif
        wr(BASE, 32'h55);
        dataAddr = BASE + 32'd4;
        #1;
        check("n_tx", {31'h0, tx}, 32'd1);
        check("n_busy", {31'h0, busy}, 32'd0);
        check("n_status", readData, 32'h0);
        tick(1);
        check("n1_status", readData, 32'h6);
        for (int j = 0; j < FRAME; j++) begin
            check("wave55", {31'h0, tx}, {31'h0, seq55[j / CPB]});
            tick(1);
        end
        check("busy_end", {31'h0, busy}, 32'd0);
        tick(2);
        check("busy_len1", lastRun, 32'(FBITS * 4));
        expBytes = '{8'h55};
        checkRx("rx55", expBytes);

        // 3. overflow
        clearLogs();
        for (int i = 1; i <= 6; i++) begin
            wr(BASE, 32'(i));
            if (i == 5) begin
                dataAddr = BASE + 32'd4;
                #1;
                check("full5", readData, 32'h5);
            end
        end
        dataAddr = BASE + 32'd4;
        #1;
        check("ovf_status", readData, 32'hD);
        wr(BASE + 32'd4, $urandom);
        #1;
        check("ovf_clear", readData, 32'h5);
        waitIdle(8 * FRAME);
        tick(2);
        expBytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        checkRx("rx_ovf", expBytes);

        // 4. back-to-back
        clearLogs();
        wr(BASE, 32'hA0);
        wr(BASE, 32'h0F);
        waitIdle(4 * FRAME);
        tick(2);
        check("busy_len2", lastRun, 32'(FBITS * 8));
        expBytes = '{8'hA0, 8'h0F};
        checkRx("rx_b2b", expBytes);

        // 5. address miss
        clearLogs();
        wr(BASE + 32'd8, 32'h41);
        dataAddr = BASE + 32'd8;
        #1;
        check("miss_read", readData, 32'h0);
        tick(FRAME);
        check("miss_busy", {31'h0, busy}, 32'd0);
        check("miss_rx", rxQ.size(), 32'd0);
        dataAddr = BASE + 32'd4;
        #1;
        check("miss_status", readData, 32'h2);

        // 6. reset mid-frame during data bit 3
        clearLogs();
        wr(BASE, 32'h07);
        tick(17);
        #2 n_reset = 1'b0;
        #1;
        check("async_tx", {31'h0, tx}, 32'd1);
        check("async_busy", {31'h0, busy}, 32'd0);
        tick(2);
        n_reset = 1'b1;
        dataAddr = BASE + 32'd4;
        #1;
        check("post_rst_status", readData, 32'h2);
        tick(FRAME + 10);
        check("post_rst_rx", rxQ.size(), 32'd0);
        check("post_rst_busy", {31'h0, busy}, 32'd0);
`ifdef UART_TX_PARITY_EN
        clearLogs();
        wr(BASE, 32'h07);
        waitIdle(2 * FRAME);
        tick(2);
        check("parity07", {31'h0, rxPar}, 32'd1);
        expBytes = '{8'h07};
        checkRx("rx07", expBytes);
`endif

        // 7. randomized register traffic
        clearLogs();
        for (int c = 0; c < 1500; c++) begin
            case ($urandom_range(0, 6))
                0, 1:    dataAddr = BASE;
                2:       dataAddr = BASE + 32'd3;
                3:       dataAddr = BASE + 32'd4;
                4:       dataAddr = BASE + 32'd6;
                5:       dataAddr = BASE + 32'd8;
                default: dataAddr = 32'h0000_2000;
            endcase
            writeData = $urandom;
            we = ($urandom_range(0, 5) == 0);
            tick(1);
        end
        we = 1'b0;
        dataAddr = BASE + 32'd4;
        waitIdle((DEPTH + 2) * FRAME);
        tick(2);
        checkRx("rx_rand", expSent);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
